// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed N-digit 7-segment scan driver with PWM dimming, ghost blanking and frame-shadowed data
module seven_seg_scan #(
   parameter int NUM_DIGITS    = 4,
   parameter int SCAN_DIV_BITS = 16,
   parameter int BLANK_CYCLES  = 16,
   parameter int HEX_MODE      = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] bcd,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    lz_blank,
   input  logic [3:0]              brightness,
   output logic [7:0]              seg_cat,
   output logic [NUM_DIGITS-1:0]   seg_an,
   output logic                    frame_start
);
   localparam int S  = SCAN_DIV_BITS;
   localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [S-1:0]  BLANK = S'(BLANK_CYCLES);
   localparam logic [DW-1:0] LAST  = DW'(NUM_DIGITS - 1);
   logic [S-1:0]            p;
   logic [DW-1:0]           d;
   logic [4*NUM_DIGITS-1:0] sh_bcd;
   logic [NUM_DIGITS-1:0]   sh_dp;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    zero;
   logic [3:0]              code;
   logic [6:0]              glyph;
   logic                    on;
   // slot prescaler, digit index, and shadow capture on the last cycle of a frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p      <= '0;
         d      <= '0;
         sh_bcd <= '0;
         sh_dp  <= '0;
      end else begin
         p <= p + 1'b1;
         if (&p) begin
            d <= (d == LAST) ? '0 : d + 1'b1;
            if (d == LAST) begin
               sh_bcd <= bcd;
               sh_dp  <= dp_mask;
            end
         end
      end
   end
   // a digit is blanked while every digit from it up to the top is zero; digit 0 always shows
   always_comb begin
      blank = '0;
      zero  = lz_blank;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero     = zero && (sh_bcd[4*i +: 4] == 4'd0);
         blank[i] = zero;
      end
   end
   // glyph lookup for the digit being scanned, gfedcba active-high
   always_comb begin
      code = sh_bcd[4*d +: 4];
      on   = (p >= BLANK) && (p[S-1:S-4] <= brightness);
      case (code)
         4'd0:    glyph = 7'b0111111;
         4'd1:    glyph = 7'b0000110;
         4'd2:    glyph = 7'b1011011;
         4'd3:    glyph = 7'b1001111;
         4'd4:    glyph = 7'b1100110;
         4'd5:    glyph = 7'b1101101;
         4'd6:    glyph = 7'b1111101;
         4'd7:    glyph = 7'b0000111;
         4'd8:    glyph = 7'b1111111;
         4'd9:    glyph = 7'b1101111;
         4'hA:    glyph = HEX_MODE != 0 ? 7'b1110111 : 7'b1000000;
         4'hB:    glyph = HEX_MODE != 0 ? 7'b1111100 : 7'b1000000;
         4'hC:    glyph = HEX_MODE != 0 ? 7'b0111001 : 7'b1000000;
         4'hD:    glyph = HEX_MODE != 0 ? 7'b1011110 : 7'b1000000;
         4'hE:    glyph = HEX_MODE != 0 ? 7'b1111001 : 7'b1000000;
         default: glyph = HEX_MODE != 0 ? 7'b1110001 : 7'b1000000;
      endcase
   end
   // registered pin drive; anodes gated by ghost blanking and PWM, cathodes held all slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_an      <= '1;
         seg_cat     <= 8'hFF;
         frame_start <= 1'b0;
      end else begin
         seg_an      <= on ? ~(NUM_DIGITS'(1) << d) : '1;
         seg_cat     <= blank[d] ? 8'hFF : ~{sh_dp[d], glyph};
         frame_start <= (p == '0) && (d == '0);
      end
   end
endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Parametrised multiplexed 7-segment scan driver: N digits, active-low anodes and cathodes, per-digit decimal points, leading-zero blanking, 16-level brightness PWM and inter-digit ghost blanking. Display data is shadowed at frame boundaries so a mid-frame update never tears. It sits between the datapath (BCD/hex value source) and the board 7-seg pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8, non-power-of-two allowed)
SCAN_DIV_BITS, 16, slot length per digit = 2^SCAN_DIV_BITS clk cycles (>=5)
BLANK_CYCLES, 16, cycles at slot start with all anodes off (< 2^(SCAN_DIV_BITS-4))
HEX_MODE, 0, 0: codes 10-15 show '-' (segment g only); 1: show A,b,C,d,E,F glyphs

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
bcd  input  4*NUM_DIGITS  digit codes; bcd[4i+3:4i] is digit i, digit 0 rightmost
dp_mask  input  NUM_DIGITS  bit i lights decimal point of digit i
lz_blank  input  1  1 = blank leading zeros
brightness  input  4  duty level, 15 = full
seg_cat  output  8  active-low cathodes {dp,g,f,e,d,c,b,a}
seg_an  output  NUM_DIGITS  active-low anodes, bit i drives digit i
frame_start  output  1  one-cycle pulse, aligned with first output cycle of digit 0 slot

Behaviour:
- Clock clk; reset synchronous active-low on rst_n, sampled at posedge clk.
- Reset: prescaler p=0, digit index d=0, shadow bcd/dp=0; outputs seg_an=all 1, seg_cat=8'hFF, frame_start=0. Reset asserted mid-frame takes effect at next edge; no partial slot completes.
- p counts 0..2^SCAN_DIV_BITS-1 every cycle; on wrap, d increments, wrapping NUM_DIGITS-1 -> 0.
- Shadow load: in cycle where p=max and d=NUM_DIGITS-1, shadow_bcd<=bcd, shadow_dp<=dp_mask; used for the whole next frame. lz_blank, brightness are live (not shadowed).
- Drive condition for slot d: on = (p >= BLANK_CYCLES) && (p[S-1:S-4] <= brightness), S=SCAN_DIV_BITS. When on, seg_an = ~(1<<d); else all 1.
- Cathodes: 7-seg pattern of shadow digit d, inverted; bit7 = ~shadow_dp[d]. Pattern forced to 8'hFF (incl. dp) when blanked by lz. Cathodes held at pattern whole slot regardless of on.
- Leading zero: with lz_blank=1, digit i (i>=1) blanked iff all shadow digits i..NUM_DIGITS-1 are 0. Digit 0 never blanked. dp of a blanked digit is suppressed.
- Glyphs (gfedcba, active-high before inversion): 0 0111111, 1 0000110, 2 1011011, 3 1001111, 4 1100110, 5 1101101, 6 1111101, 7 0000111, 8 1111111, 9 1101111; HEX_MODE=1: A 1110111, b 1111100, C 0111001, d 1011110, E 1111001, F 1110001; HEX_MODE=0 codes 10-15: 1000000.
- Latency: all outputs registered; outputs at cycle t+1 reflect (p,d) of cycle t. frame_start=1 exactly when registered outputs correspond to d=0,p=0 (first: one cycle after reset release).

Test Plan:
(Params NUM_DIGITS=4, SCAN_DIV_BITS=6, BLANK_CYCLES=2, HEX_MODE=0 unless stated; slot = 64 cycles.)
- Reset: rst_n=0 for 5 cycles mid-scan -> seg_an=4'hF, seg_cat=8'hFF, frame_start=0; release -> frame_start pulses next cycle, then every 256 cycles.
- bcd=16'h1234, brightness=15, frame after load -> slot 0: p=0,1 seg_an=4'hF; p=2..63 seg_an=4'b1110, seg_cat=8'h99; slot 3 seg_an=4'b0111, seg_cat=8'hF9.
- Change bcd 16'h1234->16'h5678 during slot 1 -> slots 2,3 still show 2,1 (8'hA4, 8'hF9); next frame digit0 shows 8 (8'h80).
- lz_blank=1, bcd=16'h0070 -> digits 3,2 seg_cat=8'hFF, digit 1 8'hF8, digit 0 8'hC0; bcd=0 -> only digit 0 shows 8'hC0; dp_mask=4'b1000 on blanked digit 3 -> stays 8'hFF.
- brightness=3 -> anode low for p=2..15 (14 cycles/slot); brightness=0 -> p=2..3 only (2 cycles).
- HEX_MODE=0 code 4'hA -> 8'hBF; HEX_MODE=1 code 4'hA -> 8'h88; dp_mask=4'b0001 with digit0=5 -> seg_cat=8'h12.
